// File: rtl/free_list_if.sv
// Rename-stage free list interface.
// Groups the enable, dispatch, retire and rollback requests with the allocation outputs.
// Signals:
//   en                global enable
//   dispatch_en       an instruction dispatches this cycle
//   dest_idx          architectural destination of the dispatching instruction
//   ROB_tail_idx      ROB slot taken by the dispatching instruction
//   retire_en         ROB head retires this cycle
//   retire_dest_idx   architectural destination of the retiring instruction
//   T_old_idx_head    physical register freed by the retirement
//   rollback_en       branch mispredict recovery
//   ROB_rollback_idx  ROB slot of the mispredicted branch
//   T_idx             physical register at the list head
//   free_valid        list is not empty
//   free_count        number of free entries
// Modports: master drives the requests (rename/ROB side), slave is the free list.
interface free_list_if #(
    parameter int unsigned NUM_PR   = 64,
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned NUM_ROB  = 8
) ();
    localparam int unsigned NUM_FL = NUM_PR - NUM_ARCH;
    localparam int unsigned FL_W   = $clog2(NUM_FL);
    localparam int unsigned PR_W   = $clog2(NUM_PR);
    localparam int unsigned AR_W   = $clog2(NUM_ARCH);
    localparam int unsigned ROB_W  = $clog2(NUM_ROB);

    logic              en;
    logic              dispatch_en;
    logic [AR_W-1:0]   dest_idx;
    logic [ROB_W-1:0]  ROB_tail_idx;
    logic              retire_en;
    logic [AR_W-1:0]   retire_dest_idx;
    logic [PR_W-1:0]   T_old_idx_head;
    logic              rollback_en;
    logic [ROB_W-1:0]  ROB_rollback_idx;
    logic [PR_W-1:0]   T_idx;
    logic              free_valid;
    logic [FL_W:0]     free_count;

    modport master (
        output en, dispatch_en, dest_idx, ROB_tail_idx,
        output retire_en, retire_dest_idx, T_old_idx_head,
        output rollback_en, ROB_rollback_idx,
        input  T_idx, free_valid, free_count
    );

    modport slave (
        input  en, dispatch_en, dest_idx, ROB_tail_idx,
        input  retire_en, retire_dest_idx, T_old_idx_head,
        input  rollback_en, ROB_rollback_idx,
        output T_idx, free_valid, free_count
    );
endinterface

// File: rtl/free_list.sv
// Physical-register free list for an R10000-style rename stage.
// Circular FIFO of free PR numbers: dispatch pops the head, retirement pushes T_old at
// the tail. Each ROB slot keeps a snapshot of the head so a mispredict restores the
// list in one cycle.
// Ports:
//   clock  single clock
//   reset  asynchronous active-high reset
//   fl_if  free_list_if slave: requests in, T_idx / free_valid / free_count out
// NUM_PR - NUM_ARCH must be a power of two so the index wraps with the pointer bits.
module free_list #(
    parameter int unsigned NUM_PR   = 64,
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned NUM_ROB  = 8,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic         clock,
    input  logic         reset,
    free_list_if.slave   fl_if
);
    localparam int unsigned NUM_FL = NUM_PR - NUM_ARCH;
    localparam int unsigned FL_W   = $clog2(NUM_FL);
    localparam int unsigned PTR_W  = FL_W + 1;
    localparam int unsigned PR_W   = $clog2(NUM_PR);
    localparam int unsigned AR_W   = $clog2(NUM_ARCH);

    logic [PR_W-1:0]  r_fl   [NUM_FL];
    logic [PTR_W-1:0] r_snap [NUM_ROB];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;

    logic [PTR_W-1:0] w_head_next;
    logic [PTR_W-1:0] w_count;
    logic             w_free_valid;
    logic             w_rollback;
    logic             w_snap;
    logic             w_pop;
    logic             w_push;

    // Wrap bit makes full (difference NUM_FL) distinguishable from empty (difference 0).
    assign w_count      = r_tail - r_head;
    assign w_free_valid = (w_count != '0);

    assign w_rollback = fl_if.en & fl_if.rollback_en;
    // A dispatch during rollback is squashed: no snapshot and no pop.
    assign w_snap     = fl_if.en & fl_if.dispatch_en & ~fl_if.rollback_en;
    assign w_pop      = w_snap & w_free_valid & (fl_if.dest_idx != AR_W'(ZERO_REG));
    assign w_push     = fl_if.en & fl_if.retire_en &
                        (fl_if.retire_dest_idx != AR_W'(ZERO_REG));

    always_comb begin
        w_head_next = r_head;
        if (w_rollback) begin
            w_head_next = r_snap[fl_if.ROB_rollback_idx];
        end else if (w_pop) begin
            w_head_next = r_head + PTR_W'(1);
        end
    end

    // Rollback only moves head; tail has not reached squashed slots, so they come back intact.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= PTR_W'(NUM_FL);
        end else if (fl_if.en) begin
            r_head <= w_head_next;
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_FL; i++) begin
                r_fl[i] <= PR_W'(NUM_ARCH + i);
            end
        end else if (w_push) begin
            r_fl[r_tail[FL_W-1:0]] <= fl_if.T_old_idx_head;
        end
    end

    // Snapshot holds the head after this cycle's pop, so rollback to a branch keeps its own tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ROB; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_snap) begin
            r_snap[fl_if.ROB_tail_idx] <= w_head_next;
        end
    end

    // No bypass: outputs depend on registered state only.
    assign fl_if.T_idx      = r_fl[r_head[FL_W-1:0]];
    assign fl_if.free_valid = w_free_valid;
    assign fl_if.free_count = w_count;

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the R10000-style rename stage. It supplies the new physical tag `T_idx` to the ROB and map table at dispatch, and takes back the retiring `T_old` from the ROB head. It is a circular FIFO of free physical register numbers. A per-ROB-entry head snapshot lets a branch mispredict restore the list in one cycle. It sits between the ROB (retire side) and the dispatch/rename logic (allocate side).

## Interface
Parameters:
- `NUM_PR`, 64: number of physical registers.
- `NUM_ARCH`, 32: number of architectural registers. The list holds `NUM_FL = NUM_PR - NUM_ARCH` entries.
- `NUM_ROB`, 8: number of ROB entries, which is also the number of snapshot slots.
- `ZERO_REG`, 31: architectural zero register. It never allocates and never frees.

Ports:
- `clock`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high; clears state immediately when asserted.
- `en`  in  1  global enable; when low, all state holds.
- `dispatch_en`  in  1  an instruction dispatches this cycle.
- `dest_idx`  in  log2(NUM_ARCH)  architectural destination of the dispatching instruction.
- `ROB_tail_idx`  in  log2(NUM_ROB)  ROB index that the dispatching instruction occupies.
- `retire_en`  in  1  the ROB head retires this cycle.
- `retire_dest_idx`  in  log2(NUM_ARCH)  architectural destination of the retiring instruction.
- `T_old_idx_head`  in  log2(NUM_PR)  physical register freed by retirement.
- `rollback_en`  in  1  branch mispredict recovery.
- `ROB_rollback_idx`  in  log2(NUM_ROB)  ROB index of the mispredicted branch.
- `T_idx`  out  log2(NUM_PR)  physical register at the list head; valid when `free_valid` is 1.
- `free_valid`  out  1  list is not empty.
- `free_count`  out  log2(NUM_FL)+1  number of free entries.

## Operation
- **Storage and pointers**
  - Storage is `fl[NUM_FL]` of PR numbers.
  - `head` and `tail` are each log2(NUM_FL)+1 bits: the index plus a wrap bit.
  - `free_count = tail - head`, computed modulo 2^(log2(NUM_FL)+1).
- **Allocate (pop)**
  - Condition: `en & dispatch_en & !rollback_en & free_valid & dest_idx != ZERO_REG`.
  - Action: `head <= head + 1`.
  - `T_idx = fl[head[idx]]` combinationally.
- **Snapshot**
  - Condition: `en & dispatch_en & !rollback_en`, whether or not an allocation happens.
  - Action: `snap[ROB_tail_idx] <=` the head value after this cycle's pop.
- **Free (push)**
  - Condition: `en & retire_en & retire_dest_idx != ZERO_REG`.
  - Action: `fl[tail[idx]] <= T_old_idx_head`, then `tail <= tail + 1`.
  - A push never overflows because of register conservation. The bench asserts that the list is never full when a push occurs.
- **Rollback**
  - Condition: `en & rollback_en`.
  - Action: `head <= snap[ROB_rollback_idx]`.
  - Squashed allocations return to the list with no copying, because `tail` has not overwritten those slots.
  - A retire push in the same cycle still occurs; `tail` is never touched by rollback.
  - A dispatch in the same cycle is ignored: no pop and no snapshot.
- **No bypass.** A push cannot be popped in the same cycle. `free_valid` reflects the registered pointers only.

## Timing
- **Reset values**
  - `head = 0`; `tail = NUM_FL` (wrap bit set, index 0), so the list is full.
  - `fl[i] = NUM_ARCH + i`.
  - `snap[*] = 0`.
  - Outputs: `T_idx = 32`, `free_valid = 1`, `free_count = 32`.
- **Latency**
  - `T_idx`, `free_valid` and `free_count` are combinational from registered state.
  - A pop advances `T_idx` on the next clock edge.
  - A push becomes allocatable one cycle after retirement.
- **Boundary conditions**
  - Empty (`free_count = 0`): `free_valid = 0`. A `dispatch_en` in that cycle pops nothing. Upstream must stall.
  - Full (`free_count = NUM_FL`): legal at reset and after all squashes; a pop is allowed.
  - Pointers wrap naturally at 2·NUM_FL; the index wraps at `NUM_FL`.
  - Simultaneous pop and push: both occur, and `free_count` is unchanged.
  - `en` low: nothing updates, including rollback.
  - Reset mid-operation: state returns to reset values asynchronously, regardless of `en`.

## Test plan
- **Reset:** assert reset mid-run -> `T_idx = 32`, `free_count = 32`, `free_valid = 1` immediately, without waiting for a clock edge.
- **Sequential allocation:** 3 dispatches with `dest = 1, 2, 3` and ROB idx 0, 1, 2 -> `T_idx` is 32, 33, 34 in successive cycles; `free_count` ends at 29.
- **Zero-register dispatch:** dispatch with `dest = 31` -> `T_idx` stays 35 and `free_count` is unchanged, but `snap[3] = 3`.
- **Rollback with concurrent retire:** allocate 32..36 at ROB 0..4, then rollback to ROB 1 while retiring ROB 0 with `T_old = 5` -> next cycle `T_idx = 34`, `free_count = 31`; 5 is allocated after PR 63.
- **Drain to empty:** 32 pops with no retirement -> `free_valid = 0`; a further dispatch leaves `head` unchanged. A retire of `T_old = 7` -> the next cycle gives `free_valid = 1`, `T_idx = 7`.
- **Steady state:** simultaneous pop and push every cycle for 100 cycles -> `free_count` stays constant, pointers wrap correctly, and every freed PR is returned in FIFO order.
